// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage of the MIPS pipeline together with the IF/ID
// pipeline register. Holds the program counter, presents it to an
// asynchronous-read instruction ROM and selects the next PC. The next PC is
// the sequential PC+4, the branch target or the jump target. The fetched
// word and its PC+4 are registered into Decode.
//
// Parameters
//   RESET_PC   PC loaded on reset (word aligned, bits [1:0] = 00)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (overrides all other inputs)
//   StallF     hold PCF this cycle (any redirect this cycle is dropped)
//   StallD     hold the IF/ID register this cycle
//   FlushD     load a bubble into the IF/ID register
//   PCSrcD     branch taken, resolved in Decode
//   PCBranchD  branch target from Decode
//   JumpD      instruction in Decode is a j
//   ImemAddr   instruction-memory address (combinational copy of PCF)
//   ImemRdata  instruction word at ImemAddr
//   PCF        current fetch PC
//   InstrD     instruction in Decode (0 when bubble)
//   PCPlus4D   PC+4 of the instruction in Decode (0 when bubble)
//   ValidD     1 = InstrD is a real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] instr_reg;
  logic [31:0] pc_plus4_d_reg;
  logic        valid_reg;

  // Wraps naturally modulo 2^32.
  assign pc_plus4 = pc_reg + 32'd4;

  // Jump target is built from the IF/ID contents: the upper nibble comes
  // from the j instruction's own PC+4 and the low bits from its index field.
  assign jump_target = {pc_plus4_d_reg[31:28], instr_reg[25:0], 2'b00};

  // Jump beats branch. The branch target is forced word aligned.
  always_comb begin
    pc_next = pc_plus4;
    if (JumpD) begin
      pc_next = jump_target;
    end else if (PCSrcD) begin
      pc_next = {PCBranchD[31:2], 2'b00};
    end
  end

  // Program counter. A stalled PC discards the redirect; the hazard unit
  // re-presents it once the stall clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else if (!StallF) begin
      pc_reg <= pc_next;
    end
  end

  // IF/ID register: stall beats flush, flush beats load. The stage never
  // squashes on its own, so a redirect must come with FlushD from outside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_reg      <= 32'd0;
      pc_plus4_d_reg <= 32'd0;
      valid_reg      <= 1'b0;
    end else if (StallD) begin
      instr_reg      <= instr_reg;
      pc_plus4_d_reg <= pc_plus4_d_reg;
      valid_reg      <= valid_reg;
    end else if (FlushD) begin
      instr_reg      <= 32'd0;
      pc_plus4_d_reg <= 32'd0;
      valid_reg      <= 1'b0;
    end else begin
      instr_reg      <= ImemRdata;
      pc_plus4_d_reg <= pc_plus4;
      valid_reg      <= 1'b1;
    end
  end

  assign ImemAddr = pc_reg;
  assign PCF      = pc_reg;
  assign InstrD   = instr_reg;
  assign PCPlus4D = pc_plus4_d_reg;
  assign ValidD   = valid_reg;

endmodule
